mem_port_arbiter4: RTL
======================

// Module: mem_port_arbiter4
// PURPOSE
//   Round-robin arbiter that shares one downstream memory/bus port among four requesters.
//   Drives the 2-bit select of a WIDTH-bit 4:1 data mux and handshakes with the port.
//   Each granted transfer is one beat. A timeout frees the port if the downstream stalls.
//   Sits between the fetch/load-store/DMA-style requesters and the single memory interface.
// PARAMETERS
//   WIDTH    32  width of each requester data word and of the muxed output y
//   TIMEOUT  16  max BUSY cycles without out_ready before forced abort (>=2)
// PORTS
//   clk        in   1      clock; all state changes on rising edge
//   resetn     in   1      asynchronous, active-low reset
//   req        in   4      request per requester; bit i = requester i
//   d0..d3     in   WIDTH  data word of requester 0..3
//   y          out  WIDTH  muxed data word of granted requester, sent downstream
//   sel        out  2      registered select of current/last grant (mux select)
//   gnt        out  4      one-hot grant; all-zero when idle
//   out_valid  out  1      y valid for downstream (high exactly in BUSY)
//   out_ready  in   1      downstream accepts y this cycle
//   done       out  1      out_valid & out_ready (combinational; beat completes)
//   err        out  1      registered 1-cycle pulse after a timeout abort
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE, gnt=0, sel=2'b00, ptr=0, cnt=0, err=0, out_valid=0.
//     y then follows d0. Reset mid-transfer drops the grant immediately; no done, no err.
//   States: IDLE, BUSY. Encoding 1 bit.
//   IDLE: sample req at the edge. If req!=0, pick the first set bit in order ptr, ptr+1, ..
//     (mod 4). Load sel, set gnt one-hot, clear cnt, go BUSY. If req==0, stay IDLE, sel holds.
//   Latency: req seen at edge N -> gnt/out_valid high after edge N (1 cycle).
//   BUSY: out_valid=1. y = d[sel] through the mux (combinational).
//     If out_ready=1 at an edge: done=1 that cycle. Next state IDLE, gnt=0, ptr=sel+1 mod 4.
//     Else cnt++. If cnt==TIMEOUT-1 and out_ready=0 at an edge: abort.
//       Abort: next state IDLE, gnt=0, ptr=sel+1, err=1 for the next cycle only.
//     out_ready and the timeout on the same edge: completion wins, no err.
//   Granted requester must hold req and its d stable until done.
//     Deassertion of req during BUSY is ignored; the grant is held to completion or timeout.
//   Requests from non-granted requesters during BUSY are not recorded; only the level in IDLE counts.
//   At least one IDLE cycle separates grants (max one beat per 2 cycles).
//   Fairness: a continuously requesting requester is granted within 4 grants.
//   ptr wraps 3->0. cnt width = clog2(TIMEOUT). cnt saturates at TIMEOUT-1 and is cleared on entering BUSY.
//   gnt is always one-hot or zero. gnt[i]=1 implies sel==i.
// STRUCTURE
//   Shared defines file arb_defs.vh holds: state codes S_IDLE/S_BUSY, NREQ=4, select codes 2'b00..2'b11.
//   One sub-module: mux4 #(.WIDTH(WIDTH)) u_mux (.d0..d3, .s(sel), .y(y)).
//   Priority pick is a small combinational function in this module.
// TESTING
//   1 Reset: resetn=0 with req=4'hF -> gnt=0, out_valid=0, sel=0, err=0. Release -> grant to req0 next cycle.
//   2 Round-robin: req=4'hF held, out_ready=1 -> grants 0,1,2,3,0 on alternate cycles; y=d_sel each BUSY cycle.
//   3 Backpressure: req=4'b0100, out_ready low 3 cycles then high -> gnt=4'b0100 for 4 cycles.
//     y=d2 stable, done in cycle 4 only, no err.
//   4 Timeout: TIMEOUT=16, req=4'b0010, out_ready=0 -> gnt drops after 16 BUSY cycles, err pulses 1 cycle, ptr=2.
//     Same run with out_ready=1 on cycle 16 -> done, no err.
//   5 Skip/wrap: ptr=3, req=4'b0101 -> grant 0, then grant 2.
//     req0 drops mid-BUSY -> grant held until out_ready.
//   6 Async reset mid-BUSY: resetn low between edges -> gnt=0 and out_valid=0 immediately; after release, IDLE with ptr=0.

Source files
------------

// File: rtl/mem_port_arbiter4_pkg.sv
// Shared types and helpers for the four-requester round-robin memory port arbiter.
//   state_t  : IDLE/BUSY arbiter state (1-bit encoding)
//   rr_pick  : first requester set at or after the rotating pointer
package mem_port_arbiter4_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_3 = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  // Returns ptr when nothing is requesting; callers gate on |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter4_mux4.sv
// 4:1 data mux feeding the shared downstream port.
//   d0..d3 : requester data words
//   s      : select
//   y      : selected word (combinational)
module mux4 import mem_port_arbiter4_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (s)
      SEL_0: y = d0;
      SEL_1: y = d1;
      SEL_2: y = d2;
      SEL_3: y = d3;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter sharing one downstream memory port among four requesters.
// One beat per grant; a stalled downstream is abandoned after TIMEOUT busy cycles.
//   clk, resetn : clock, async active-low reset
//   req         : per-requester request level (sampled only while idle)
//   d0..d3      : requester data words
//   y           : data of the granted requester (mux on sel)
//   sel         : registered select of current/last grant
//   gnt         : registered one-hot grant, zero when idle
//   out_valid   : y valid downstream (high exactly while busy)
//   out_ready   : downstream accepts y
//   done        : beat completes this cycle (combinational)
//   err         : one-cycle pulse after a timeout abort
module mem_port_arbiter4 import mem_port_arbiter4_pkg::*; #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             err
);

  localparam int unsigned        CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, sel_n, pick;
  logic [NREQ-1:0]    gnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_n;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  // Next-state: grant from IDLE, finish on out_ready, abort on stall timeout.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    cnt_n   = cnt;
    err_n   = 1'b0;
    pick    = rr_pick(req, ptr);
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_n = S_BUSY;
          sel_n   = pick;
          gnt_n   = NREQ'(1) << pick;
          cnt_n   = '0;
        end
      end
      S_BUSY: begin
        // Completion takes precedence over a coincident timeout.
        if (out_ready) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          ptr_n   = sel + SEL_W'(1);
        end else if (cnt == CNT_MAX) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          ptr_n   = sel + SEL_W'(1);
          err_n   = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign out_valid = (state == S_BUSY);
  assign done      = out_valid & out_ready;

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s  (sel),
    .y  (y)
  );

endmodule
